// File: rtl/traffic_light_fsm.sv
// Two-way intersection phase sequencer with pedestrian walk, timed by ticks
// derived from the clk_mstr square wave sampled in the clk_50_mhz domain.
module traffic_light_fsm #(
  parameter int GREEN_MIN  = 5,
  parameter int GREEN_MAX  = 20,
  parameter int EW_GREEN_T = 8,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 1,
  parameter int CNT_BITS   = 5
) (
  input  logic                clk_50_mhz,
  input  logic                rst,
  input  logic                clk_mstr,
  input  logic                ew_car,
  input  logic                ped_btn,
  output logic [2:0]          ns_lights,
  output logic [2:0]          ew_lights,
  output logic                walk,
  output logic                ped_pending,
  output logic [CNT_BITS-1:0] sec_left,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR_A = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR_B = 3'd5
  } phase_t;

  localparam logic [CNT_BITS-1:0] L_GREEN_MAX = CNT_BITS'(GREEN_MAX);
  localparam logic [CNT_BITS-1:0] L_EW_GREEN  = CNT_BITS'(EW_GREEN_T);
  localparam logic [CNT_BITS-1:0] L_YELLOW    = CNT_BITS'(YELLOW_T);
  localparam logic [CNT_BITS-1:0] L_ALLRED    = CNT_BITS'(ALLRED_T);
  localparam logic [CNT_BITS:0]   L_GREEN_MIN = (CNT_BITS+1)'(GREEN_MIN);
  localparam logic                EARLY_EN    = (GREEN_MIN <= GREEN_MAX);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic r_mstr_s1, r_mstr_s2, r_mstr_s3;
  logic r_car_s1, r_car_s2;
  logic r_ped_s1, r_ped_s2;

  phase_t              r_state;
  logic [CNT_BITS-1:0] r_sec_left;
  logic [CNT_BITS-1:0] r_elapsed;
  logic [2:0]          r_ns;
  logic [2:0]          r_ew;
  logic                r_walk;
  logic                r_ped_pending;

  logic                w_tick;
  logic                w_early;
  logic                w_advance;
  logic                w_illegal;
  logic                w_enter_ewg;
  phase_t              w_seq_next;
  phase_t              w_state_next;
  logic [CNT_BITS-1:0] w_dur;
  logic [CNT_BITS-1:0] w_sec_next;

  assign w_tick = r_mstr_s2 & ~r_mstr_s3;

  // Early NS green exit once the minimum green has been served and there is demand.
  assign w_early = EARLY_EN && (r_state == NS_G) &&
                   (({1'b0, r_elapsed} + (CNT_BITS+1)'(1)) >= L_GREEN_MIN) &&
                   (r_car_s2 | r_ped_pending);

  assign w_advance = w_tick && ((r_sec_left == CNT_BITS'(1)) || w_early);

  always_comb begin
    w_seq_next = AR_B;
    w_dur      = L_ALLRED;
    w_illegal  = 1'b0;
    case (r_state)
      NS_G: begin w_seq_next = NS_Y; w_dur = L_YELLOW;    end
      NS_Y: begin w_seq_next = AR_A; w_dur = L_ALLRED;    end
      AR_A: begin w_seq_next = EW_G; w_dur = L_EW_GREEN;  end
      EW_G: begin w_seq_next = EW_Y; w_dur = L_YELLOW;    end
      EW_Y: begin w_seq_next = AR_B; w_dur = L_ALLRED;    end
      AR_B: begin w_seq_next = NS_G; w_dur = L_GREEN_MAX; end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_sec_next   = r_sec_left;
    if (w_illegal) begin
      w_state_next = AR_B;
      w_sec_next   = L_ALLRED;
    end else if (w_advance) begin
      w_state_next = w_seq_next;
      w_sec_next   = w_dur;
    end else if (w_tick) begin
      w_sec_next   = r_sec_left - CNT_BITS'(1);
    end
  end

  assign w_enter_ewg = (w_state_next == EW_G) && (r_state != EW_G);

  always_ff @(posedge clk_50_mhz) begin
    if (rst) begin
      r_mstr_s1     <= 1'b0;
      r_mstr_s2     <= 1'b0;
      r_mstr_s3     <= 1'b0;
      r_car_s1      <= 1'b0;
      r_car_s2      <= 1'b0;
      r_ped_s1      <= 1'b0;
      r_ped_s2      <= 1'b0;
      r_state       <= AR_B;
      r_sec_left    <= L_ALLRED;
      r_elapsed     <= '0;
      r_ns          <= RED;
      r_ew          <= RED;
      r_walk        <= 1'b0;
      r_ped_pending <= 1'b0;
    end else begin
      r_mstr_s1 <= clk_mstr;
      r_mstr_s2 <= r_mstr_s1;
      r_mstr_s3 <= r_mstr_s2;
      r_car_s1  <= ew_car;
      r_car_s2  <= r_car_s1;
      r_ped_s1  <= ped_btn;
      r_ped_s2  <= r_ped_s1;

      r_state    <= w_state_next;
      r_sec_left <= w_sec_next;

      if ((w_state_next == NS_G) && (r_state != NS_G))
        r_elapsed <= '0;
      else if ((r_state == NS_G) && w_tick)
        r_elapsed <= r_elapsed + CNT_BITS'(1);

      // A press coinciding with EW_G entry is kept for the next cycle of phases.
      if (r_ped_s2)
        r_ped_pending <= 1'b1;
      else if (w_enter_ewg)
        r_ped_pending <= 1'b0;

      if (w_enter_ewg)
        r_walk <= r_ped_pending;
      else if (w_state_next != EW_G)
        r_walk <= 1'b0;

      case (w_state_next)
        NS_G:    begin r_ns <= GRN; r_ew <= RED; end
        NS_Y:    begin r_ns <= YEL; r_ew <= RED; end
        EW_G:    begin r_ns <= RED; r_ew <= GRN; end
        EW_Y:    begin r_ns <= RED; r_ew <= YEL; end
        default: begin r_ns <= RED; r_ew <= RED; end
      endcase
    end
  end

  assign ns_lights   = r_ns;
  assign ew_lights   = r_ew;
  assign walk        = r_walk;
  assign ped_pending = r_ped_pending;
  assign sec_left    = r_sec_left;
  assign state       = r_state;

endmodule
